tpu_instr_sequencer: RTL and testbench
======================================

TPU_INSTR_SEQUENCER -- requirements
Module: tpu_instr_sequencer

Interface
REQ-001 SHALL have parameter INSTR_W, default 32: instruction width; opcode is [INSTR_W-1:INSTR_W-4], operand is [INSTR_W-5:0].
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024: maximum cycles to wait for a unit done.
REQ-003 SHALL have parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-004 clk_i  in  1  single clock; all logic on posedge.
REQ-005 rst_i  in  1  reset, synchronous, active-low.
REQ-006 run_i  in  1  level; enables fetching of new instructions.
REQ-007 clear_i  in  1  pulse; leaves HALTED/ERROR.
REQ-008 iq_empty_i  in  1  instruction queue holds no entries.
REQ-009 iq_instr_i  in  INSTR_W  queue read data; valid the cycle after iq_rd_o.
REQ-010 iq_rd_o  out  1  one-cycle queue pop request.
REQ-011 wl_start_o, mm_start_o, act_start_o, st_start_o  out  1 each  one-cycle start pulses to weight-load, matmul, activation and store units.
REQ-012 wl_done_i, mm_done_i, act_done_i, st_done_i  in  1 each  unit completion pulses.
REQ-013 arg_o  out  INSTR_W-4  operand of the current instruction; held stable from ISSUE until return to IDLE.
REQ-014 busy_o  out  1  FSM is in WAIT_INSTR, ISSUE or BUSY.
REQ-015 halted_o  out  1  FSM is in HALTED.
REQ-016 error_o  out  1  FSM is in ERROR.
REQ-017 err_code_o  out  2  error cause: 0 none, 1 illegal opcode, 2 timeout, 3 MATMUL issued before weights were loaded.
REQ-018 retired_o  out  CNT_W  count of retired instructions.

Function
REQ-019 Opcodes SHALL be: 0 NOP, 1 LOAD_W, 2 MATMUL, 3 ACTIVATE, 4 STORE, 15 HALT; all other values are illegal.
REQ-020 FSM states SHALL be IDLE, WAIT_INSTR, ISSUE, BUSY, HALTED and ERROR.
REQ-021 IDLE: if run_i=1 and iq_empty_i=0, the block SHALL assert iq_rd_o for one cycle (cycle T) and go to WAIT_INSTR.
REQ-022 WAIT_INSTR: the block SHALL capture iq_instr_i into the instruction register at the end of T+1 and go to ISSUE.
REQ-023 ISSUE (cycle T+2) SHALL decode the instruction as follows:
- NOP: retired_o+1, next state IDLE.
- HALT: retired_o+1, next state HALTED.
- LOAD_W, MATMUL, ACTIVATE, STORE: the matching *_start_o is high for this cycle only, next state BUSY.
- Illegal opcode: next state ERROR, err_code_o=1.
REQ-024 MATMUL in ISSUE while weights_loaded=0 SHALL raise no start pulse and go to ERROR with err_code_o=3.
REQ-025 weights_loaded SHALL be set when the wl_done_i of a LOAD_W completes; only reset SHALL clear it.
REQ-026 BUSY SHALL sample only the done input of the issued unit; done inputs of other units, and any done during ISSUE, SHALL be ignored.
REQ-027 Matching done in BUSY SHALL give retired_o+1 and next state IDLE.
REQ-028 The timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-029 If the counter reaches TIMEOUT_CYC-1 without a matching done, the block SHALL go to ERROR with err_code_o=2.
REQ-030 A done arriving in the same cycle as the timeout SHALL take priority, and the instruction retires.
REQ-031 Deasserting run_i SHALL NOT abort an in-flight instruction; the block stops only on its return to IDLE.
REQ-032 HALTED and ERROR SHALL ignore run_i and all done inputs.
REQ-033 clear_i in HALTED or ERROR SHALL return the FSM to IDLE next cycle and set err_code_o=0; retired_o and weights_loaded SHALL be kept.
REQ-034 clear_i in any other state SHALL be ignored.
REQ-035 retired_o SHALL wrap modulo 2^CNT_W.
REQ-036 Minimum issue period SHALL be 3 cycles per NOP/HALT; a unit op SHALL take 3 cycles plus its done latency.
REQ-037 iq_rd_o SHALL never assert while iq_empty_i=1 or outside IDLE.

Reset
REQ-038 While rst_i=0 at a clock edge, the block SHALL enter IDLE.
REQ-039 Under reset, all start outputs and iq_rd_o SHALL be 0.
REQ-040 Under reset, busy_o, halted_o and error_o SHALL be 0.
REQ-041 Under reset, err_code_o, arg_o, retired_o, weights_loaded and the timeout counter SHALL be 0.
REQ-042 Reset asserted mid-BUSY SHALL abandon the instruction with no start re-issue after release.

Verification
REQ-043 Bench SHALL cover: queue [LOAD_W arg 5, MATMUL arg 7, HALT], done 4 cycles after each start, run_i=1 -> wl_start at T+2 with arg_o=5, then mm_start with arg_o=7, then halted_o=1 and retired_o=3.
REQ-044 Bench SHALL cover: MATMUL first after reset -> no mm_start_o, error_o=1, err_code_o=3; then clear_i -> IDLE, err_code_o=0.
REQ-045 Bench SHALL cover: opcode 9 -> error_o=1, err_code_o=1, retired_o unchanged.
REQ-046 Bench SHALL cover: STORE with st_done_i never asserted, TIMEOUT_CYC=16 -> error_o=1, err_code_o=2 after 15 BUSY cycles; act_done_i pulsed during the wait is ignored.
REQ-047 Bench SHALL cover: rst_i=0 for one cycle during BUSY of ACTIVATE -> all outputs 0, IDLE; a late act_done_i has no effect.
REQ-048 Bench SHALL cover: run_i=0 with a non-empty queue -> iq_rd_o stays 0; run_i dropped mid-BUSY -> instruction retires and no further pop occurs.

Source files
------------

// File: rtl/tpu_instr_sequencer.sv
// tpu_instr_sequencer: pops instructions, pulses unit starts, waits for done, tracks retire count and errors
module tpu_instr_sequencer #(
  parameter int INSTR_W     = 32,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               run_i,
  input  logic               clear_i,
  input  logic               iq_empty_i,
  input  logic [INSTR_W-1:0] iq_instr_i,
  output logic               iq_rd_o,
  output logic               wl_start_o,
  output logic               mm_start_o,
  output logic               act_start_o,
  output logic               st_start_o,
  input  logic               wl_done_i,
  input  logic               mm_done_i,
  input  logic               act_done_i,
  input  logic               st_done_i,
  output logic [INSTR_W-5:0] arg_o,
  output logic               busy_o,
  output logic               halted_o,
  output logic               error_o,
  output logic [1:0]         err_code_o,
  output logic [CNT_W-1:0]   retired_o
);
  typedef enum logic [2:0] {IDLE, WAIT_INSTR, ISSUE, BUSY, HALTED, ERROR} state_e;
  localparam logic [3:0] OP_NOP = 4'd0, OP_LDW = 4'd1, OP_MM = 4'd2, OP_ACT = 4'd3, OP_ST = 4'd4, OP_HALT = 4'd15;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_e             state_q;
  logic [3:0]         op_q;
  logic [INSTR_W-5:0] arg_q;
  logic [3:0]         start_q;
  logic [1:0]         err_q;
  logic [CNT_W-1:0]   ret_q;
  logic               wl_q;
  logic [TW-1:0]      tmo_q;
  logic [3:0]         new_op;
  logic               done_hit;
  logic               tmo_hit;
  assign new_op  = iq_instr_i[INSTR_W-1 -: 4];
  assign tmo_hit = tmo_q == TW'(TIMEOUT_CYC - 2);
  always_comb begin
    done_hit = op_q == OP_LDW ? wl_done_i :
               op_q == OP_MM  ? mm_done_i :
               op_q == OP_ACT ? act_done_i :
               op_q == OP_ST  ? st_done_i : 1'b0;
  end
  // start pulses are decided while the instruction is captured so they land exactly in ISSUE
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      arg_q   <= '0;
      start_q <= '0;
      err_q   <= '0;
      ret_q   <= '0;
      wl_q    <= 1'b0;
      tmo_q   <= '0;
    end else begin
      start_q <= '0;
      case (state_q)
        IDLE: if (run_i && !iq_empty_i) state_q <= WAIT_INSTR;
        WAIT_INSTR: begin
          op_q    <= new_op;
          arg_q   <= iq_instr_i[INSTR_W-5:0];
          start_q <= {new_op == OP_ST, new_op == OP_ACT, new_op == OP_MM && wl_q, new_op == OP_LDW};
          state_q <= ISSUE;
        end
        ISSUE: begin
          tmo_q <= '0;
          case (op_q)
            OP_NOP: begin
              ret_q   <= ret_q + CNT_W'(1);
              state_q <= IDLE;
            end
            OP_HALT: begin
              ret_q   <= ret_q + CNT_W'(1);
              state_q <= HALTED;
            end
            OP_LDW, OP_ACT, OP_ST: state_q <= BUSY;
            OP_MM: begin
              state_q <= wl_q ? BUSY : ERROR;
              err_q   <= wl_q ? err_q : 2'd3;
            end
            default: begin
              state_q <= ERROR;
              err_q   <= 2'd1;
            end
          endcase
        end
        BUSY: begin
          if (done_hit) begin
            ret_q   <= ret_q + CNT_W'(1);
            wl_q    <= wl_q | (op_q == OP_LDW);
            state_q <= IDLE;
          end else if (tmo_hit) begin
            err_q   <= 2'd2;
            state_q <= ERROR;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        HALTED, ERROR: if (clear_i) begin
          state_q <= IDLE;
          err_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign iq_rd_o     = rst_i && state_q == IDLE && run_i && !iq_empty_i;
  assign wl_start_o  = start_q[0];
  assign mm_start_o  = start_q[1];
  assign act_start_o = start_q[2];
  assign st_start_o  = start_q[3];
  assign arg_o       = arg_q;
  assign busy_o      = state_q == WAIT_INSTR || state_q == ISSUE || state_q == BUSY;
  assign halted_o    = state_q == HALTED;
  assign error_o     = state_q == ERROR;
  assign err_code_o  = err_q;
  assign retired_o   = ret_q;
endmodule

// File: tb/tb_tpu_instr_sequencer.sv
// tb_tpu_instr_sequencer: directed cycle-exact checks of the instruction sequencer
module tb_tpu_instr_sequencer;
  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        run_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        iq_empty_i;
  logic [31:0] iq_instr_i = '0;
  logic        iq_rd_o;
  logic        wl_start_o, mm_start_o, act_start_o, st_start_o;
  logic        wl_done_i, mm_done_i, act_done_i, st_done_i;
  logic [27:0] arg_o;
  logic        busy_o, halted_o, error_o;
  logic [1:0]  err_code_o;
  logic [15:0] retired_o;
  logic [31:0] qmem [0:15];
  int          qn = 0;
  int          qi = 0;
  logic [3:0]  sr_wl = '0;
  logic [3:0]  sr_mm = '0;
  logic        fd_act = 1'b0;
  logic        fd_st = 1'b0;
  int          total = 0;
  int          passed = 0;
  tpu_instr_sequencer #(.INSTR_W(32), .TIMEOUT_CYC(16), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .run_i(run_i), .clear_i(clear_i),
    .iq_empty_i(iq_empty_i), .iq_instr_i(iq_instr_i), .iq_rd_o(iq_rd_o),
    .wl_start_o(wl_start_o), .mm_start_o(mm_start_o), .act_start_o(act_start_o), .st_start_o(st_start_o),
    .wl_done_i(wl_done_i), .mm_done_i(mm_done_i), .act_done_i(act_done_i), .st_done_i(st_done_i),
    .arg_o(arg_o), .busy_o(busy_o), .halted_o(halted_o), .error_o(error_o),
    .err_code_o(err_code_o), .retired_o(retired_o)
  );
  always #5 clk = ~clk;
  assign iq_empty_i = qi == qn;
  assign wl_done_i  = sr_wl[3];
  assign mm_done_i  = sr_mm[3];
  assign act_done_i = fd_act;
  assign st_done_i  = fd_st;
  // queue read data appears the cycle after the pop; weight-load and matmul units answer 4 cycles after start
  always @(posedge clk) begin
    if (iq_rd_o) begin
      iq_instr_i <= qmem[qi];
      qi <= qi + 1;
    end
    sr_wl <= {sr_wl[2:0], wl_start_o};
    sr_mm <= {sr_mm[2:0], mm_start_o};
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [3:0] op, input logic [27:0] arg);
    qmem[qn] = {op, arg};
    qn = qn + 1;
  endtask
  initial begin
    push(4'd1, 28'd5);
    push(4'd2, 28'd7);
    push(4'd15, 28'd0);
    run_i = 1'b1;
    tick(2);
    chk("rst_rd", iq_rd_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_halt", halted_o, 0);
    chk("rst_err", error_o, 0);
    chk("rst_code", err_code_o, 0);
    chk("rst_arg", arg_o, 0);
    chk("rst_ret", retired_o, 0);
    chk("rst_starts", {wl_start_o, mm_start_o, act_start_o, st_start_o}, 0);
    rst_i = 1'b1;
    #1;
    chk("s1_rd_T", iq_rd_o, 1);
    tick(1);
    chk("s1_rd_T1", iq_rd_o, 0);
    chk("s1_busy_wait", busy_o, 1);
    tick(1);
    chk("s1_wl_start", wl_start_o, 1);
    chk("s1_arg5", arg_o, 5);
    tick(1);
    chk("s1_wl_once", wl_start_o, 0);
    tick(6);
    chk("s1_mm_start", mm_start_o, 1);
    chk("s1_arg7", arg_o, 7);
    chk("s1_ret1", retired_o, 1);
    tick(8);
    chk("s1_halted", halted_o, 1);
    chk("s1_ret3", retired_o, 3);
    chk("s1_busy0", busy_o, 0);
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    chk("s1_clr_halt", halted_o, 0);
    chk("s1_clr_ret", retired_o, 3);
    rst_i = 1'b0;
    tick(1);
    rst_i = 1'b1;
    chk("s2_ret_rst", retired_o, 0);
    push(4'd2, 28'd9);
    tick(2);
    chk("s2_no_mm", mm_start_o, 0);
    tick(1);
    chk("s2_err", error_o, 1);
    chk("s2_code3", err_code_o, 3);
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    chk("s2_clr_err", error_o, 0);
    chk("s2_clr_code", err_code_o, 0);
    push(4'd0, 28'd0);
    push(4'd9, 28'd1);
    tick(3);
    chk("s3_nop_ret", retired_o, 1);
    tick(3);
    chk("s3_err", error_o, 1);
    chk("s3_code1", err_code_o, 1);
    chk("s3_ret_keep", retired_o, 1);
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    push(4'd4, 28'h11);
    tick(2);
    chk("s4_st_start", st_start_o, 1);
    tick(6);
    fd_act = 1'b1;
    tick(1);
    fd_act = 1'b0;
    chk("s4_busy_act", busy_o, 1);
    chk("s4_arg", arg_o, 28'h11);
    tick(8);
    chk("s4_busy15", busy_o, 1);
    chk("s4_noerr15", error_o, 0);
    tick(1);
    chk("s4_err", error_o, 1);
    chk("s4_code2", err_code_o, 2);
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    push(4'd3, 28'h22);
    tick(2);
    chk("s5_act_start", act_start_o, 1);
    tick(2);
    rst_i = 1'b0;
    tick(1);
    chk("s5_busy", busy_o, 0);
    chk("s5_halt", halted_o, 0);
    chk("s5_err", error_o, 0);
    chk("s5_code", err_code_o, 0);
    chk("s5_arg", arg_o, 0);
    chk("s5_ret", retired_o, 0);
    chk("s5_starts", {wl_start_o, mm_start_o, act_start_o, st_start_o}, 0);
    chk("s5_rd", iq_rd_o, 0);
    rst_i = 1'b1;
    tick(1);
    fd_act = 1'b1;
    tick(1);
    fd_act = 1'b0;
    chk("s5_late_busy", busy_o, 0);
    chk("s5_late_ret", retired_o, 0);
    chk("s5_no_restart", act_start_o, 0);
    run_i = 1'b0;
    push(4'd1, 28'h33);
    push(4'd0, 28'd0);
    tick(3);
    chk("s6_norun_rd", iq_rd_o, 0);
    chk("s6_norun_busy", busy_o, 0);
    run_i = 1'b1;
    #1;
    chk("s6_rd", iq_rd_o, 1);
    tick(2);
    chk("s6_wl_start", wl_start_o, 1);
    tick(1);
    run_i = 1'b0;
    tick(4);
    chk("s6_ret", retired_o, 1);
    chk("s6_busy", busy_o, 0);
    chk("s6_no_pop", iq_rd_o, 0);
    tick(2);
    chk("s6_idle_busy", busy_o, 0);
    chk("s6_idle_rd", iq_rd_o, 0);
    chk("s6_idle_ret", retired_o, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
